// File: rtl/hnf_sram_mask_pipe_if.sv
// Request/response bundle for the masked SRAM pipe.
// Both channels use valid/ready: a beat transfers on the rising edge where valid and ready are both 1;
// the payload is held stable by the sender while valid=1 and ready=0.
interface hnf_sram_mask_pipe_if #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 512,
  parameter int RAM_MASK_WIDTH = 16
);
  localparam int W = RAM_DATA_WIDTH * RAM_MASK_WIDTH;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [RAM_ADDR_WIDTH-1:0] req_addr;
  logic [RAM_MASK_WIDTH-1:0] req_wmask;
  logic [W-1:0]              req_data;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [W-1:0]              rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_data, rd_ready,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_data, rd_ready,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/hnf_sram_mask_pipe.sv
// Segment-masked single-port SRAM with zero-fill after reset and a credit-limited
// read pipeline feeding an output FIFO of RD_LATENCY+1 entries.
module hnf_sram_mask_pipe #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 512,
  parameter int RAM_MASK_WIDTH = 16,
  parameter int RD_LATENCY     = 1,
  parameter int INIT_EN        = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  hnf_sram_mask_pipe_if.slave   bus,
  output logic                  o_init_done,
  output logic                  o_dbg_state
);
  localparam int W     = RAM_DATA_WIDTH * RAM_MASK_WIDTH;
  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int FD    = RD_LATENCY + 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                    r_state;
  logic [RAM_ADDR_WIDTH-1:0] r_init_addr;
  logic [W-1:0]              r_mem [DEPTH];
  logic [W-1:0]              r_fifo [4];
  logic [1:0]                r_wr_ptr;
  logic [1:0]                r_rd_ptr;
  logic [1:0]                r_cnt;

  logic                      w_ready;
  logic                      w_rd_acc;
  logic                      w_wr_acc;
  logic                      w_push;
  logic                      w_pop;
  logic [W-1:0]              w_push_data;
  logic [1:0]                w_inflight;
  logic [2:0]                w_occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      r_init_addr <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (&r_init_addr) r_state <= ST_RUN;
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Gating with i_rst_n makes READY/INIT_DONE drop the instant reset asserts, even when
  // INIT_EN=0 leaves the state register parked in RUN.
  assign o_init_done = i_rst_n && (r_state == ST_RUN);
  assign o_dbg_state = r_state;

  // Credits cover reads still in the pipe plus words already in the FIFO.
  assign w_occ         = 3'(w_inflight) + 3'(r_cnt);
  assign w_ready       = o_init_done && (w_occ < 3'(FD));
  assign bus.req_ready = w_ready;
  assign w_wr_acc      = bus.req_valid && w_ready && bus.req_we;
  assign w_rd_acc      = bus.req_valid && w_ready && !bus.req_we;

  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_addr] <= '0;
    end else if (w_wr_acc) begin
      for (int gi = 0; gi < RAM_MASK_WIDTH; gi++) begin
        if (bus.req_wmask[gi])
          r_mem[bus.req_addr][gi*RAM_DATA_WIDTH +: RAM_DATA_WIDTH] <=
            bus.req_data[gi*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
      end
    end
  end

  generate
    if (RD_LATENCY >= 2) begin : g_lat2
      logic         r_s1_vld;
      logic [W-1:0] r_s1_data;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_s1_vld <= 1'b0;
        else          r_s1_vld <= w_rd_acc;
      end

      always_ff @(posedge i_clk) begin
        if (w_rd_acc) r_s1_data <= r_mem[bus.req_addr];
      end

      assign w_push      = r_s1_vld;
      assign w_push_data = r_s1_data;
      assign w_inflight  = {1'b0, r_s1_vld};
    end else begin : g_lat1
      // Single-cycle latency: the array word lands in the FIFO at the acceptance edge.
      assign w_push      = w_rd_acc;
      assign w_push_data = r_mem[bus.req_addr];
      assign w_inflight  = 2'd0;
    end
  endgenerate

  assign w_pop = (r_cnt != 2'd0) && bus.rd_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == 2'(FD-1)) ? 2'd0 : r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == 2'(FD-1)) ? 2'd0 : r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.rd_valid = (r_cnt != 2'd0);
  assign bus.rd_data  = bus.rd_valid ? r_fifo[r_rd_ptr] : '0;
endmodule

// File: tb/tb_hnf_sram_mask_pipe.sv
// Bench for hnf_sram_mask_pipe: small array, two-cycle read latency, model-based scoreboard.
`timescale 1ns/1ps
module tb_hnf_sram_mask_pipe;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int MW    = 16;
  localparam int L     = 2;
  localparam int W     = DW * MW;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hnf_sram_mask_pipe_if #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RAM_MASK_WIDTH(MW)) bus ();
  logic init_done;
  logic dbg_state;

  hnf_sram_mask_pipe #(
    .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RAM_MASK_WIDTH(MW),
    .RD_LATENCY(L), .INIT_EN(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_init_done(init_done), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] last_pop;
  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int n_pop = 0;
  bit head_seen = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- compare process (mid-cycle) ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rel_cyc = 0;
      check("rst_req_ready", W'(bus.req_ready), '0);
      check("rst_rd_valid",  W'(bus.rd_valid),  '0);
      check("rst_init_done", W'(init_done),     '0);
      check("rst_rd_data",   bus.rd_data,       '0);
      exp_q.delete();
      acc_q.delete();
      head_seen = 0;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    end else begin
      rel_cyc++;
      check("init_done", W'(init_done), W'(rel_cyc > DEPTH));
      check("req_ready", W'(bus.req_ready), W'((rel_cyc > DEPTH) && (exp_q.size() < L + 1)));
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rd_valid", W'(bus.rd_valid), '0);
        end else begin
          check("rd_data", bus.rd_data, exp_q[0]);
          if (!head_seen) begin
            check("rd_latency_min", W'((cyc - acc_q[0]) >= L), W'(1));
            head_seen = 1;
          end
          if (bus.rd_ready) begin
            last_pop = bus.rd_data;
            n_pop++;
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            head_seen = 0;
          end
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_we) begin
          for (int gi = 0; gi < MW; gi++)
            if (bus.req_wmask[gi])
              model_mem[bus.req_addr][gi*DW +: DW] = bus.req_data[gi*DW +: DW];
        end else begin
          exp_q.push_back(model_mem[bus.req_addr]);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] m,
                      input logic [W-1:0] d);
    int  k = 0;
    bit  ok = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_data  = d;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk);
      #1;
      k++;
    end
    bus.req_valid = 1'b0;
    if (!ok) check("send_timeout", W'(ok), W'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), '0);
  endtask

  task automatic wait_init();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!init_done && n < 60);
    check("init_cycles", W'(n), W'(DEPTH + 1));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] lit;
  logic [W-1:0] d7;
  int acc;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_data  = '0;
    bus.rd_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init();

    // fresh array reads as zero everywhere
    for (int a = 0; a < DEPTH; a++) send(1'b0, AW'(a), '0, '0);
    wait_idle();
    check("init_zero_last", last_pop, '0);
    check("init_zero_count", W'(n_pop), W'(DEPTH));

    // two masked writes to separate segments of one word
    send(1'b1, 4'd3, 16'h0001, {16{8'h5A}});
    send(1'b1, 4'd3, 16'h8000, {16{8'hC3}});
    send(1'b0, 4'd3, '0, '0);
    wait_idle();
    lit = '0;
    lit[7:0]     = 8'h5A;
    lit[127:120] = 8'hC3;
    check("mask_model", model_mem[3], lit);
    check("mask_read", last_pop, lit);

    // read directly after write: new data, valid exactly L cycles after acceptance
    d7 = rand_word();
    send(1'b1, 4'd7, 16'hFFFF, d7);
    send(1'b0, 4'd7, '0, '0);
    @(negedge clk);
    check("raw_valid_early", W'(bus.rd_valid), '0);
    @(negedge clk);
    check("raw_valid_on_time", W'(bus.rd_valid), W'(1));
    check("raw_data", bus.rd_data, d7);
    @(posedge clk);
    #1;
    wait_idle();

    // distinct data in every word so ordering errors show up
    for (int a = 0; a < DEPTH; a++) send(1'b1, AW'(a), 16'hFFFF, rand_word());

    // back-pressure: only L+1 reads fit, then drain in order
    bus.rd_ready = 1'b0;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr = AW'(acc + 2);
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stall_ready_low", W'(bus.req_ready), '0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("stall_accepts", W'(acc), W'(L + 1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b1;
    wait_idle();

    // sustained one-per-cycle reads
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.req_addr = AW'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check("throughput_32", W'(acc), W'(32));
    wait_idle();

    // randomized mixed traffic with random back-pressure
    for (int i = 0; i < 500; i++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_we    = $urandom_range(0, 1);
      bus.req_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.req_wmask = MW'($urandom());
      bus.req_data  = rand_word();
      bus.rd_ready  = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    wait_idle();

    // reset with two reads in flight
    bus.rd_ready = 1'b0;
    send(1'b0, 4'd5, '0, '0);
    send(1'b0, 4'd6, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", W'(bus.rd_valid), '0);
    check("async_rst_req_ready", W'(bus.req_ready), '0);
    check("async_rst_init_done", W'(init_done), '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rd_ready = 1'b1;
    wait_init();
    n_pop = 0;
    for (int a = 0; a < DEPTH; a++) send(1'b0, AW'(a), '0, '0);
    wait_idle();
    check("reinit_zero_count", W'(n_pop), W'(DEPTH));
    check("reinit_zero_last", last_pop, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hnf_sram_mask_pipe.md
HNF_SRAM_MASK_PIPE -- requirements
Module: hnf_sram_mask_pipe

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 10: word address width; depth = 2**RAM_ADDR_WIDTH.
REQ-002 SHALL have parameter RAM_DATA_WIDTH, default 512: width of one mask segment in bits.
REQ-003 SHALL have parameter RAM_MASK_WIDTH, default 16: segments per word; word width W = RAM_DATA_WIDTH*RAM_MASK_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1 (legal 1 or 2): cycles from read acceptance to earliest RD_VALID.
REQ-005 SHALL have parameter INIT_EN, default 1: 1 = zero-fill the array after reset; 0 = no fill.
REQ-006 SHALL have one clock and an asynchronous active-low reset: CLK input 1 (all state on rising edge); RST_N input 1 (async assert, active low).
REQ-007 SHALL have REQ_VALID input 1: request present.
REQ-008 SHALL have REQ_READY output 1: request accepted when REQ_VALID & REQ_READY.
REQ-009 SHALL have REQ_WE input 1: 1 = write, 0 = read.
REQ-010 SHALL have REQ_ADDR input RAM_ADDR_WIDTH: word address.
REQ-011 SHALL have REQ_WMASK input RAM_MASK_WIDTH: per-segment write enable; ignored on reads.
REQ-012 SHALL have REQ_DATA input W: full-word write data; segment gi = bits [gi*RAM_DATA_WIDTH +: RAM_DATA_WIDTH].
REQ-013 SHALL have RD_VALID output 1: read data present.
REQ-014 SHALL have RD_READY input 1: consumer accepts when RD_VALID & RD_READY.
REQ-015 SHALL have RD_DATA output W: full-word read data.
REQ-016 SHALL have INIT_DONE output 1: array initialised; requests may be accepted.

Function
REQ-017 SHALL implement a two-state FSM: INIT and RUN; after reset, INIT if INIT_EN=1, else RUN.
REQ-018 In INIT, SHALL write all-zero W bits to one address per cycle, with a RAM_ADDR_WIDTH-bit counter running 0 to depth-1, and SHALL enter RUN the cycle after writing depth-1 (depth cycles total).
REQ-019 INIT_DONE SHALL be 1 exactly when the FSM is in RUN.
REQ-020 REQ_READY SHALL be 1 only in RUN with (reads in flight + output buffer occupancy) < RD_LATENCY+1; it SHALL NOT depend combinationally on REQ_VALID, REQ_WE, or RD_READY.
REQ-021 An accepted write SHALL update only segments with REQ_WMASK[gi]=1, at the acceptance edge; mask all-zero = accepted no-op.
REQ-022 An accepted read SHALL return the word as it stands after all writes accepted in earlier cycles (a read the cycle after a write to the same address returns the new data).
REQ-023 Read data SHALL enter an output FIFO of depth RD_LATENCY+1, with RD_VALID no earlier than RD_LATENCY cycles after acceptance.
REQ-024 Read data SHALL be returned in acceptance order; no data lost or duplicated under any RD_READY pattern.
REQ-025 With RD_READY held 1 and a read offered every cycle, SHALL sustain one read accepted and one returned per cycle after the initial RD_LATENCY cycles.
REQ-026 RD_DATA SHALL hold stable while RD_VALID=1 and RD_READY=0.
REQ-027 On a simultaneous FIFO push and pop with the FIFO full, SHALL keep occupancy unchanged and lose no data.
REQ-028 REQ_ADDR, REQ_WMASK and REQ_DATA SHALL be don't-care when REQ_VALID=0 or REQ_READY=0.

Reset
REQ-029 On RST_N=0, SHALL immediately drive REQ_READY=0, RD_VALID=0 and INIT_DONE=0, and clear the FSM, init counter, in-flight count and FIFO.
REQ-030 RD_DATA SHALL be all-zero in reset.
REQ-031 Array contents SHALL NOT be reset directly; zeroing happens only through INIT.
REQ-032 Reset asserted mid-INIT or mid-read SHALL discard all pending reads and SHALL restart INIT from address 0 after release (INIT_EN=1).

Verification
REQ-033 SHALL cover: INIT_EN=1, RAM_ADDR_WIDTH=4 -> INIT_DONE=0 for 16 cycles after release, then 1; read of each address 0..15 -> 0.
REQ-034 SHALL cover: write addr 3, mask 16'h0001, data all-5A; then write addr 3, mask 16'h8000, data all-C3; then read addr 3 -> segment 0 = 5A.., segment 15 = C3.., others 0.
REQ-035 SHALL cover: write addr 7 at cycle t, read addr 7 at t+1 -> new data returned; RD_LATENCY=2 -> RD_VALID first at t+3.
REQ-036 SHALL cover: RD_READY=0 with back-to-back reads -> exactly RD_LATENCY+1 reads accepted, then REQ_READY=0; RD_READY=1 -> data drains in order with RD_DATA stable while stalled.
REQ-037 SHALL cover: RD_READY=1 with 32 consecutive reads -> 32 accepted in 32 cycles, in-order data.
REQ-038 SHALL cover: RST_N pulsed with 2 reads in flight -> RD_VALID=0 immediately, no stale data after release, INIT restarts at address 0.
